// File: rtl/bnn_neuron_scheduler.sv
// Time-shares one XNOR-popcount neuron datapath across N_NEURONS logical neurons.
// Holds per-neuron weights/thresholds and collects fire bits over a req/ack handshake.
module bnn_neuron_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int IN_W      = 8,
  parameter int CNT_W     = 4,
  parameter int AW        = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IN_W-1:0]      x_in,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [IN_W-1:0]      cfg_data,
  output logic                 nrn_req,
  output logic [IN_W-1:0]      nrn_x,
  output logic [IN_W-1:0]      nrn_w,
  output logic [CNT_W-1:0]     nrn_thr,
  input  logic                 nrn_ack,
  input  logic                 nrn_fire,
  output logic [N_NEURONS-1:0] y_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t               r_state;
  logic [IN_W-1:0]      r_weight [N_NEURONS];
  logic [CNT_W-1:0]     r_thr    [N_NEURONS];
  logic [N_NEURONS-1:0] r_shadow;
  logic [AW-1:0]        r_idx;
  logic [7:0]           r_wait;
  logic                 r_req;
  logic [IN_W-1:0]      r_x;
  logic [IN_W-1:0]      r_w;
  logic [CNT_W-1:0]     r_thr_o;
  logic [N_NEURONS-1:0] r_y;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic [AW-1:0]        w_idx_nxt;
  logic [7:0]           w_wait_nxt;
  logic [N_NEURONS-1:0] w_shadow_upd;
  logic                 w_last;
  logic                 w_cfg_hit;

  assign w_idx_nxt  = r_idx + AW'(1);
  assign w_wait_nxt = r_wait + 8'd1;
  assign w_last     = (r_idx == AW'(N_NEURONS - 1));
  assign w_cfg_hit  = (r_state == S_IDLE) && cfg_we && (int'(cfg_addr) < N_NEURONS);

  // Shadow including the fire bit being acknowledged this cycle.
  always_comb begin
    w_shadow_upd        = r_shadow;
    w_shadow_upd[r_idx] = nrn_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_idx    <= '0;
      r_wait   <= '0;
      r_req    <= 1'b0;
      r_x      <= '0;
      r_w      <= '0;
      r_thr_o  <= '0;
      r_y      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_weight[i] <= '0;
        r_thr[i]    <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_cfg_hit) begin
        if (cfg_sel) r_thr[cfg_addr]    <= cfg_data[CNT_W-1:0];
        else         r_weight[cfg_addr] <= cfg_data;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_REQ;
            r_x     <= x_in;
            r_idx   <= '0;
            r_wait  <= '0;
            r_w     <= r_weight[0];
            r_thr_o <= r_thr[0];
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_REQ: begin
          if (nrn_ack) begin
            r_shadow <= w_shadow_upd;
            r_wait   <= '0;
            if (w_last) begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
              r_busy  <= 1'b0;
              r_y     <= w_shadow_upd;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= w_idx_nxt;
              r_w     <= r_weight[w_idx_nxt];
              r_thr_o <= r_thr[w_idx_nxt];
            end
          end else if (w_wait_nxt == 8'(TIMEOUT)) begin
            // Abort: err lands TIMEOUT+1 cycles after the last advance.
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_wait  <= '0;
            r_err   <= 1'b1;
          end else begin
            r_wait <= w_wait_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign nrn_req = r_req;
  assign nrn_x   = r_x;
  assign nrn_w   = r_w;
  assign nrn_thr = r_thr_o;
  assign y_out   = r_y;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_bnn_neuron_scheduler.sv
// Scoreboard bench for bnn_neuron_scheduler: a stall-programmable datapath responder,
// a queue of expected done/err events and a monitor that checks them.
module tb_bnn_neuron_scheduler;
  localparam int N     = 4;
  localparam int IN_W  = 8;
  localparam int CNT_W = 4;
  localparam int AW    = 2;
  localparam int TO    = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [IN_W-1:0]  x_in;
  logic             cfg_we;
  logic             cfg_sel;
  logic [AW-1:0]    cfg_addr;
  logic [IN_W-1:0]  cfg_data;
  logic             nrn_req;
  logic [IN_W-1:0]  nrn_x;
  logic [IN_W-1:0]  nrn_w;
  logic [CNT_W-1:0] nrn_thr;
  logic             nrn_ack;
  logic             nrn_fire;
  logic [N-1:0]     y_out;
  logic             busy;
  logic             done;
  logic             err;

  bnn_neuron_scheduler #(
    .N_NEURONS(N), .IN_W(IN_W), .CNT_W(CNT_W), .AW(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .nrn_req(nrn_req), .nrn_x(nrn_x), .nrn_w(nrn_w), .nrn_thr(nrn_thr),
    .nrn_ack(nrn_ack), .nrn_fire(nrn_fire),
    .y_out(y_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_err;
    logic [N-1:0] y;
    int           cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  logic [IN_W-1:0]  m_w   [N];
  logic [CNT_W-1:0] m_thr [N];
  logic [N-1:0]     m_last_y;
  int               stall_cfg [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [N-1:0] model_y(input logic [IN_W-1:0] x);
    logic [N-1:0]    y;
    logic [IN_W-1:0] agree;
    for (int i = 0; i < N; i++) begin
      agree = ~(x ^ m_w[i]);
      y[i]  = ($countones(agree) >= int'(m_thr[i]));
    end
    return y;
  endfunction

  // Datapath stand-in: neuron k is acked after stall_cfg[k] wait cycles.
  int  nidx   = 0;
  int  waited = 0;
  bit  acked  = 0;
  logic [IN_W-1:0] agree_dp;
  initial begin
    nrn_ack  = 1'b0;
    nrn_fire = 1'b0;
    forever begin
      @(negedge clk);
      if (!nrn_req) begin
        nidx     = 0;
        waited   = 0;
        acked    = 0;
        nrn_ack  = 1'($urandom_range(0, 1));
        nrn_fire = 1'($urandom_range(0, 1));
      end else begin
        if (acked) begin
          nidx++;
          waited = 0;
        end
        if (nidx < N && waited >= stall_cfg[nidx]) begin
          agree_dp = ~(nrn_x ^ nrn_w);
          nrn_ack  = 1'b1;
          nrn_fire = ($countones(agree_dp) >= int'(nrn_thr));
          acked    = 1;
        end else begin
          nrn_ack  = 1'b0;
          nrn_fire = 1'($urandom_range(0, 1));
          acked    = 0;
          waited++;
        end
      end
    end
  end

  // Monitor
  logic [N-1:0] prev_y = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_y = '0;
      end else begin
        if (done || err) begin
          if (exp_q.size() == 0) begin
            chk("spurious_event", {30'b0, done, err}, 32'b0);
          end else begin
            e = exp_q.pop_front();
            chk("event_is_err", {31'b0, err}, {31'b0, e.is_err});
            chk("event_is_done", {31'b0, done}, {31'b0, !e.is_err});
            chk("event_cycle", cyc, e.cyc);
            chk("event_y_out", {28'b0, y_out}, {28'b0, e.y});
            chk("event_busy_low", {31'b0, busy}, 32'b0);
          end
        end else begin
          chk("y_out_stable", {28'b0, y_out}, {28'b0, prev_y});
        end
        prev_y = y_out;
      end
    end
  end

  task automatic cfg_write(input bit sel, input int addr, input logic [IN_W-1:0] data, input bit upd);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = AW'(addr);
    cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
    if (upd) begin
      if (sel) m_thr[addr] = data[CNT_W-1:0];
      else     m_w[addr]   = data;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_within_budget", {31'b0, busy}, 32'b0);
  endtask

  // Issues start from a negedge; returns at the negedge of the first REQ cycle.
  task automatic run(input logic [IN_W-1:0] x, output int c_start);
    exp_t e;
    int   base;
    wait_idle();
    x_in  = x;
    start = 1'b1;
    @(posedge clk);
    #1;
    c_start  = cyc;
    e.is_err = 0;
    base     = c_start;
    for (int i = 0; i < N; i++) begin
      if (stall_cfg[i] >= TO) begin
        e.is_err = 1;
        base += TO;
        break;
      end
      base += stall_cfg[i] + 1;
    end
    e.cyc = base;
    e.y   = e.is_err ? m_last_y : model_y(x);
    if (!e.is_err) m_last_y = e.y;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("req_first_cycle", {31'b0, nrn_req}, 32'd1);
    chk("busy_first_cycle", {31'b0, busy}, 32'd1);
    chk("nrn_x_latched", {24'b0, nrn_x}, {24'b0, x});
    chk("nrn_w_neuron0", {24'b0, nrn_w}, {24'b0, m_w[0]});
    chk("nrn_thr_neuron0", {28'b0, nrn_thr}, {28'b0, m_thr[0]});
  endtask

  // Returns at the negedge of the done/err cycle.
  task automatic wait_end(output int busy_cnt, output int w5a_cnt);
    int n = 0;
    busy_cnt = 0;
    w5a_cnt  = 0;
    forever begin
      if (busy) busy_cnt++;
      if (nrn_req && nrn_w == 8'h5A) w5a_cnt++;
      if (done || err) break;
      if (n >= 300) begin
        chk("run_finished", {31'b0, done || err}, 32'd1);
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic set_stalls(input int s0, input int s1, input int s2, input int s3);
    stall_cfg[0] = s0;
    stall_cfg[1] = s1;
    stall_cfg[2] = s2;
    stall_cfg[3] = s3;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_w[i]   = '0;
      m_thr[i] = '0;
    end
    m_last_y = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, bc, wc;
    logic [IN_W-1:0] wts [N];
    rst      = 1'b1;
    start    = 1'b0;
    x_in     = '0;
    cfg_we   = 1'b0;
    cfg_sel  = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    model_reset();
    set_stalls(0, 0, 0, 0);
    #1;
    chk("rst_req", {31'b0, nrn_req}, 32'b0);
    chk("rst_busy", {31'b0, busy}, 32'b0);
    chk("rst_done_err", {30'b0, done, err}, 32'b0);
    chk("rst_y_out", {28'b0, y_out}, 32'b0);
    chk("rst_nrn_w", {24'b0, nrn_w}, 32'b0);
    @(negedge clk);
    @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk);

    // Directed configuration and zero-wait run
    wts[0] = 8'hA5; wts[1] = 8'h5A; wts[2] = 8'hF0; wts[3] = 8'h00;
    for (int i = 0; i < N; i++) begin
      cfg_write(1'b0, i, wts[i], 1'b1);
      cfg_write(1'b1, i, 8'd4, 1'b1);
    end
    run(8'hA5, c);
    wait_end(bc, wc);
    chk("t1_done_cycle", cyc - c, 32'd4);
    chk("t1_y_out", {28'b0, y_out}, 32'b1101);
    chk("t1_busy_cycles", bc, 32'd4);

    // Neuron 1 stalled 3 cycles
    set_stalls(0, 3, 0, 0);
    run(8'hA5, c);
    wait_end(bc, wc);
    chk("t2_w_hold", wc, 32'd4);
    chk("t2_done_cycle", cyc - c, 32'd7);
    chk("t2_y_out", {28'b0, y_out}, 32'b1101);

    // Never acknowledged: timeout
    set_stalls(255, 255, 255, 255);
    run(8'h33, c);
    wait_end(bc, wc);
    chk("t3_err", {31'b0, err}, 32'd1);
    chk("t3_err_cycle", cyc - c, 32'd15);
    chk("t3_y_kept", {28'b0, y_out}, 32'b1101);

    // start and cfg_we during a run are dropped
    set_stalls(2, 2, 2, 2);
    run(8'hA5, c);
    cfg_write(1'b0, 0, 8'hFF, 1'b0);
    start = 1'b1;
    x_in  = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    wait_end(bc, wc);
    chk("t4_y_out", {28'b0, y_out}, 32'b1101);
    set_stalls(0, 0, 0, 0);
    run(8'h00, c);
    wait_end(bc, wc);
    chk("t4_readback_y", {28'b0, y_out}, 32'b1111);

    // Randomised runs with boundary stalls
    for (int r = 0; r < 25; r++) begin
      int nw = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++)
        cfg_write(1'($urandom_range(0, 1)), $urandom_range(0, N - 1), 8'($urandom), 1'b1);
      for (int i = 0; i < N; i++) stall_cfg[i] = $urandom_range(0, 4);
      if ($urandom_range(0, 5) == 0)
        stall_cfg[$urandom_range(0, N - 1)] = $urandom_range(TO - 1, TO);
      run(8'($urandom), c);
      wait_end(bc, wc);
    end

    // Reset during a stalled run
    for (int i = 0; i < N; i++) begin
      cfg_write(1'b0, i, wts[i], 1'b1);
      cfg_write(1'b1, i, 8'd4, 1'b1);
    end
    set_stalls(0, 0, 0, 0);
    run(8'hA5, c);
    wait_end(bc, wc);
    set_stalls(10, 0, 0, 0);
    run(8'hA5, c);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req", {31'b0, nrn_req}, 32'b0);
    chk("rst_mid_busy", {31'b0, busy}, 32'b0);
    chk("rst_mid_y_out", {28'b0, y_out}, 32'b0);
    chk("rst_mid_done_err", {30'b0, done, err}, 32'b0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk);

    // Only thresholds rewritten: relies on weights having been cleared
    set_stalls(0, 1, 0, 2);
    for (int i = 0; i < N; i++) cfg_write(1'b1, i, 8'd8, 1'b1);
    run(8'h00, c);
    wait_end(bc, wc);
    chk("post_rst_y_out", {28'b0, y_out}, 32'b1111);

    for (int r = 0; r < 8; r++) begin
      cfg_write(1'b0, $urandom_range(0, N - 1), 8'($urandom), 1'b1);
      cfg_write(1'b1, $urandom_range(0, N - 1), 8'($urandom_range(0, 8)), 1'b1);
      for (int i = 0; i < N; i++) stall_cfg[i] = $urandom_range(0, 3);
      run(8'($urandom), c);
      wait_end(bc, wc);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bnn_neuron_scheduler.md
# bnn_neuron_scheduler

Sequencer that time-shares one binary (XNOR-popcount) neuron datapath across `N_NEURONS` logical neurons of a BNN layer. It holds per-neuron weights and thresholds in a small register file. On `start` it latches an input activation vector and issues one request per neuron to the shared datapath over a req/ack handshake. It collects each fire bit into a layer output word, and sits between the top-level I/O/config logic and the neuron datapath.

## Interface
Parameters:
- `N_NEURONS`, default 4: logical neurons per layer; legal range 2..8.
- `IN_W`, default 8: activation/weight vector width.
- `CNT_W`, default 4: threshold width; must hold 0..`IN_W`.
- `AW`, default 2: config address width; equals ceil(log2(`N_NEURONS`)).
- `TIMEOUT`, default 15: maximum cycles to wait for `nrn_ack` per neuron; range 1..255.

Ports:
- `clk`, in, 1: single clock; everything is rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: run request; sampled only in IDLE.
- `x_in`, in, `IN_W`: input activation vector; latched on an accepted `start`.
- `cfg_we`, in, 1: config write strobe.
- `cfg_sel`, in, 1: 0 selects a weight write; 1 selects a threshold write.
- `cfg_addr`, in, `AW`: neuron index to write.
- `cfg_data`, in, `IN_W`: write data; thresholds use bits [`CNT_W`-1:0].
- `nrn_req`, out, 1: request to the shared datapath.
- `nrn_x`, out, `IN_W`: latched activation vector.
- `nrn_w`, out, `IN_W`: weight of the current neuron.
- `nrn_thr`, out, `CNT_W`: threshold of the current neuron.
- `nrn_ack`, in, 1: datapath result valid.
- `nrn_fire`, in, 1: datapath result bit; valid only with `nrn_ack`.
- `y_out`, out, `N_NEURONS`: layer result; bit i is the fire bit of neuron i.
- `busy`, out, 1: a run is in progress.
- `done`, out, 1: one-cycle pulse when `y_out` is updated.
- `err`, out, 1: one-cycle pulse when a run is aborted on timeout.

## Operation
- Reset (async, `rst`=1):
  - State goes to IDLE.
  - `busy`, `done`, `err` and `nrn_req` = 0.
  - `y_out`, `nrn_x`, `nrn_w` and `nrn_thr` = 0.
  - All weights, all thresholds, the neuron index and the wait counter = 0.
- Config writes:
  - Accepted only in IDLE with `cfg_we`=1.
  - `cfg_sel`=0 performs `weight[cfg_addr]` <= `cfg_data`.
  - `cfg_sel`=1 performs `thr[cfg_addr]` <= `cfg_data`[`CNT_W`-1:0].
  - A write while `busy`=1 is dropped silently.
  - An address >= `N_NEURONS` is ignored.
- FSM states: IDLE, REQ.
- IDLE:
  - On `start`=1, latch `x_in` into `nrn_x`, set index=0, clear the wait counter and go to REQ.
  - `start` is ignored in every other state.
- REQ, base behaviour:
  - `nrn_req`=1 and `busy`=1.
  - `nrn_w` = `weight[index]` and `nrn_thr` = `thr[index]`; both are registered and stable while `nrn_req` is high and unacknowledged.
- REQ, on `nrn_ack`=1:
  - Capture `nrn_fire` into `shadow[index]` and clear the wait counter.
  - If index = `N_NEURONS`-1: go to IDLE, drop `nrn_req`, copy shadow into `y_out` and pulse `done`.
  - Otherwise: increment index and stay in REQ. `nrn_req` stays high and the operands advance the next cycle (back-to-back).
- REQ, no ack:
  - The wait counter increments.
  - When the counter equals `TIMEOUT` with no ack, go to IDLE, drop `nrn_req`, pulse `err` and leave `y_out` unchanged.
- `nrn_ack` outside REQ is ignored.
- `y_out` changes only on a `done` cycle or on reset.

## Timing
- `start` sampled high at edge t:
  - `busy`=1 and `nrn_req`=1 from t+1.
  - Operands for neuron 0 are valid at t+1.
- With zero-wait ack (ack in the same cycle as the request), REQ lasts cycles t+1..t+N.
- In cycle t+N+1:
  - `y_out` is valid, `done`=1 and `busy`=0.
  - A new `start` is accepted in this same cycle.
- Each neuron's stall cycles add one-for-one to the latency.
- Timeout:
  - `err` is asserted exactly `TIMEOUT`+1 cycles after the last advance if no ack arrives.
  - `busy`=0 in the same cycle.
- Reset mid-run:
  - Immediate abort with all outputs at reset values.
  - No `done` or `err` pulse.
  - Weights and thresholds are cleared.

## Test plan
- Configure `thr`=4 for all neurons and weights 0xA5, 0x5A, 0xF0, 0x00. Run `start` with `x_in`=0xA5 and an ack every request cycle with fire = popcount(~(x^w)) >= thr. Required: `done` at t+5, `y_out`=4'b1101, `busy` high for exactly 4 cycles.
- Same run with the ack for neuron 1 delayed 3 cycles. Required: `nrn_w` holds 0x5A for 4 cycles, `done` at t+8, `y_out`=4'b1101.
- With `TIMEOUT`=15, never ack. Required: `err` pulse at t+16, `busy`=0 in that cycle, `done` never asserts, `y_out` keeps its previous value 4'b1101.
- Pulse `start` and `cfg_we` (write weight 0 = 0xFF) during a run. Required: the run completes unchanged and a read-back run shows weight 0 still 0xA5.
- Assert `rst` at t+2 of a stalled run. Required: `nrn_req`, `busy` and `y_out` are 0 immediately. A reconfigured run after reset produces the correct `y_out`.
